// File: rtl/atm_balance_arbiter.sv
// Two-terminal round-robin arbiter that serialises ATM balance operations onto one shared memory port.
// Define ATM_ARB_TRANSFER_EN to build in account-to-account transfers (RD_DST/WR_DST states).
module atm_balance_arbiter #(
    parameter int NUM_ACCT = 10,
    parameter int BAL_W    = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [1:0]       Op0,
    input  logic [1:0]       Op1,
    input  logic [3:0]       Idx0,
    input  logic [3:0]       Idx1,
    input  logic [3:0]       DestIdx0,
    input  logic [3:0]       DestIdx1,
    input  logic [BAL_W-1:0] Amt0,
    input  logic [BAL_W-1:0] Amt1,
    output logic [3:0]       MemAddr,
    output logic             MemWe,
    output logic [BAL_W-1:0] MemWData,
    input  logic [BAL_W-1:0] MemRData,
    output logic [1:0]       Gnt,
    output logic [1:0]       Done,
    output logic             Err,
    output logic [BAL_W-1:0] Balance
);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_WDR  = 2'b01;
    localparam logic [1:0] OP_DEP  = 2'b10;
    localparam logic [1:0] OP_XFR  = 2'b11;
    localparam logic [4:0] ACCT_LIMIT = 5'(NUM_ACCT);

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
`ifdef ATM_ARB_TRANSFER_EN
        RD_DST,
`endif
        EXEC,
`ifdef ATM_ARB_TRANSFER_EN
        WR_DST,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       idx_q, idx_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic [BAL_W-1:0] src_q, src_d;
    logic             err_q, err_d;
    logic [BAL_W-1:0] bal_q, bal_d;

`ifdef ATM_ARB_TRANSFER_EN
    logic [3:0]       dst_q, dst_d;
    logic [BAL_W-1:0] dbal_q, dbal_d;
    logic [BAL_W:0]   xfr_sum;
    logic             dst_ok;
`else
    logic             dest_unused;
    assign dest_unused = ^{DestIdx0, DestIdx1};
`endif

    logic [1:0]       req_vec;
    logic             pick;
    logic             src_ok;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W-1:0] wdr_res;

    logic [3:0]       mem_addr;
    logic             mem_we;
    logic [BAL_W-1:0] mem_wdata;
    logic [1:0]       gnt;
    logic [1:0]       done;

    assign req_vec = {Req1, Req0};

    // On a tie the terminal that was not served last wins; a lone request always wins.
    always_comb begin
        pick = req_vec[1];
        if (req_vec == 2'b11) begin
            pick = ~last_q;
        end
    end

    assign src_ok  = ({1'b0, idx_q} < ACCT_LIMIT);
    assign dep_sum = {1'b0, src_q} + {1'b0, amt_q};
    assign wdr_res = src_q - amt_q;

`ifdef ATM_ARB_TRANSFER_EN
    assign dst_ok  = ({1'b0, dst_q} < ACCT_LIMIT);
    assign xfr_sum = {1'b0, dbal_q} + {1'b0, amt_q};
`endif

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        op_d      = op_q;
        idx_d     = idx_q;
        amt_d     = amt_q;
        src_d     = src_q;
        err_d     = err_q;
        bal_d     = bal_q;
`ifdef ATM_ARB_TRANSFER_EN
        dst_d     = dst_q;
        dbal_d    = dbal_q;
`endif
        mem_addr  = 4'd0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        gnt       = 2'b00;
        done      = 2'b00;

        if (state_q != IDLE) begin
            gnt = win_q ? 2'b10 : 2'b01;
        end

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    win_d   = pick;
                    op_d    = pick ? Op1  : Op0;
                    idx_d   = pick ? Idx1 : Idx0;
                    amt_d   = pick ? Amt1 : Amt0;
`ifdef ATM_ARB_TRANSFER_EN
                    dst_d   = pick ? DestIdx1 : DestIdx0;
`endif
                    state_d = RD_SRC;
                end
            end

            RD_SRC: begin
                mem_addr = idx_q;
                src_d    = MemRData;
                state_d  = EXEC;
`ifdef ATM_ARB_TRANSFER_EN
                if (op_q == OP_XFR) begin
                    state_d = RD_DST;
                end
`endif
            end

`ifdef ATM_ARB_TRANSFER_EN
            RD_DST: begin
                mem_addr = dst_q;
                dbal_d   = MemRData;
                state_d  = EXEC;
            end
`endif

            EXEC: begin
                mem_addr = idx_q;
                state_d  = DONE;
                err_d    = 1'b0;
                bal_d    = src_q;
                if (!src_ok) begin
                    err_d = 1'b1;
                end else begin
                    case (op_q)
                        OP_READ: begin
                            err_d = 1'b0;
                        end
                        OP_WDR: begin
                            if (amt_q <= src_q) begin
                                mem_we    = 1'b1;
                                mem_wdata = wdr_res;
                                bal_d     = wdr_res;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_DEP: begin
                            if (dep_sum[BAL_W]) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = dep_sum[BAL_W-1:0];
                                bal_d     = dep_sum[BAL_W-1:0];
                            end
                        end
                        default: begin
`ifdef ATM_ARB_TRANSFER_EN
                            // Source is debited here; the credit follows in WR_DST.
                            if (!dst_ok || (amt_q > src_q) || xfr_sum[BAL_W] || (dst_q == idx_q)) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = wdr_res;
                                bal_d     = wdr_res;
                                state_d   = WR_DST;
                            end
`else
                            err_d = 1'b1;
`endif
                        end
                    endcase
                end
            end

`ifdef ATM_ARB_TRANSFER_EN
            WR_DST: begin
                mem_addr  = dst_q;
                mem_we    = 1'b1;
                mem_wdata = xfr_sum[BAL_W-1:0];
                err_d     = 1'b0;
                state_d   = DONE;
            end
`endif

            DONE: begin
                done    = win_q ? 2'b10 : 2'b01;
                last_d  = win_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= '0;
            idx_q   <= '0;
            amt_q   <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            bal_q   <= '0;
`ifdef ATM_ARB_TRANSFER_EN
            dst_q   <= '0;
            dbal_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            amt_q   <= amt_d;
            src_q   <= src_d;
            err_q   <= err_d;
            bal_q   <= bal_d;
`ifdef ATM_ARB_TRANSFER_EN
            dst_q   <= dst_d;
            dbal_q  <= dbal_d;
`endif
        end
    end

    assign MemAddr  = mem_addr;
    assign MemWe    = mem_we;
    assign MemWData = mem_wdata;
    assign Gnt      = gnt;
    assign Done     = done;
    assign Err      = err_q;
    assign Balance  = bal_q;

endmodule
